secuenciador_comparador_d_i: RTL and testbench

SECUENCIADOR_COMPARADOR_D_I -- requirements
Module: secuenciador_comparador_d_i

---
 rtl/secuenciador_comparador_d_i_pkg.sv | 12 +
 rtl/secuenciador_comparador_d_i_if.sv | 49 ++++
 rtl/celda_d_i.sv | 12 +
 rtl/secuenciador_comparador_d_i.sv | 126 ++++++++++++
 tb/tb_secuenciador_comparador_d_i.sv | 138 +++++++++++++
 5 files changed

// File: rtl/secuenciador_comparador_d_i_pkg.sv
// Shared definitions for the bit-serial unsigned comparator: FSM encodings and default operand width.
package secuenciador_comparador_d_i_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/secuenciador_comparador_d_i_if.sv
// Operand/result handshake bundle for secuenciador_comparador_d_i.
// The igual signal exists only when COMPARE_IGUAL_EN is defined.
interface secuenciador_comparador_d_i_if
  import secuenciador_comparador_d_i_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] palabraA;
  logic [WIDTH-1:0] palabraB;
  logic             resultado;
  logic             resultado_valid;
  logic             resultado_ready;
  logic             busy;
`ifdef COMPARE_IGUAL_EN
  logic             igual;
`endif

  modport master (
    output start_valid,
    output palabraA,
    output palabraB,
    output resultado_ready,
    input  start_ready,
    input  resultado,
    input  resultado_valid,
`ifdef COMPARE_IGUAL_EN
    input  igual,
`endif
    input  busy
  );

  modport slave (
    input  start_valid,
    input  palabraA,
    input  palabraB,
    input  resultado_ready,
    output start_ready,
    output resultado,
    output resultado_valid,
`ifdef COMPARE_IGUAL_EN
    output igual,
`endif
    output busy
  );

endinterface

// File: rtl/celda_d_i.sv
// One-bit greater-than cell: propagates "A > B so far" from the less significant bits.
module celda_d_i (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic c_out
);

  // A strictly greater bit wins; an equal bit passes the lower-order verdict through.
  assign c_out = (a & ~b) | (~(a ^ b) & c_in);

endmodule

// File: rtl/secuenciador_comparador_d_i.sv
// Bit-serial unsigned comparator: latches two operands and walks them LSB first through one cell.
// Optional feature macro: COMPARE_IGUAL_EN adds the registered equality flag igual.
module secuenciador_comparador_d_i
  import secuenciador_comparador_d_i_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                          clk,
  input logic                          reset,
  secuenciador_comparador_d_i_if.slave bus
);

  localparam int               IDX_W    = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic             resultado_q;
  logic             valid_q;
  logic             busy_q;
  logic             ready_q;
  logic             a_bit_d;
  logic             b_bit_d;
  logic             carry_d;

  // Bit selection by mask keeps the index free of width-mismatch concerns for any WIDTH.
  assign a_bit_d = |(a_q & (WIDTH'(1) << idx_q));
  assign b_bit_d = |(b_q & (WIDTH'(1) << idx_q));

  celda_d_i u_celda (
    .a     (a_bit_d),
    .b     (b_bit_d),
    .c_in  (carry_q),
    .c_out (carry_d)
  );

`ifdef COMPARE_IGUAL_EN
  logic eq_acc_q;
  logic igual_q;
  logic eq_bit_d;

  assign eq_bit_d  = ~(a_bit_d ^ b_bit_d);
  assign bus.igual = igual_q;
`endif

  assign bus.start_ready     = ready_q;
  assign bus.busy            = busy_q;
  assign bus.resultado       = resultado_q;
  assign bus.resultado_valid = valid_q;

  // Sequencer: accept in IDLE, one bit per cycle in RUN, hold the verdict in DONE until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      resultado_q <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
`ifdef COMPARE_IGUAL_EN
      eq_acc_q    <= 1'b0;
      igual_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            a_q      <= bus.palabraA;
            b_q      <= bus.palabraB;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= RUN;
`ifdef COMPARE_IGUAL_EN
            eq_acc_q <= 1'b1;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          carry_q  <= carry_d;
`ifdef COMPARE_IGUAL_EN
          eq_acc_q <= eq_acc_q & eq_bit_d;
`endif
          if (idx_q == IDX_LAST) begin
            // The index parks on the last bit so it never leaves 0..WIDTH-1.
            resultado_q <= carry_d;
            valid_q     <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
`ifdef COMPARE_IGUAL_EN
            igual_q     <= eq_acc_q & eq_bit_d;
`endif
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end
        DONE: begin
          if (bus.resultado_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_comparador_d_i.sv
// Directed-vector bench for secuenciador_comparador_d_i at WIDTH=3.
module tb_secuenciador_comparador_d_i;

  localparam int W = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  secuenciador_comparador_d_i_if #(.WIDTH(W)) bus ();

  secuenciador_comparador_d_i #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a/b, scramble the pins during RUN, and check cycle-exact completion.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic exp_gt, input logic exp_eq, input logic rdy);
    bus.palabraA        = a;
    bus.palabraB        = b;
    bus.resultado_ready = rdy;
    bus.start_valid     = 1'b1;
    check_bit({tag, "_start_ready"}, bus.start_ready, 1'b1);
    step();
    bus.start_valid = 1'b0;
    bus.palabraA    = 3'd0;
    bus.palabraB    = 3'd7;
    check_bit({tag, "_busy"}, bus.busy, 1'b1);
    check_bit({tag, "_not_ready"}, bus.start_ready, 1'b0);
    for (int i = 1; i < W; i++) begin
      step();
      check_bit({tag, "_early_valid"}, bus.resultado_valid, 1'b0);
    end
    step();
    check_bit({tag, "_valid"}, bus.resultado_valid, 1'b1);
    check_bit({tag, "_resultado"}, bus.resultado, exp_gt);
    check_bit({tag, "_busy_done"}, bus.busy, 1'b0);
`ifdef COMPARE_IGUAL_EN
    check_bit({tag, "_igual"}, bus.igual, exp_eq);
`else
    if (exp_eq === 1'bx) $display("note: unexpected unknown equality flag in %s", tag);
`endif
  endtask

  task automatic release_ok(input string tag);
    bus.resultado_ready = 1'b1;
    step();
    check_bit({tag, "_drop_valid"}, bus.resultado_valid, 1'b0);
    check_bit({tag, "_idle"}, bus.start_ready, 1'b1);
  endtask

  initial begin
    reset               = 1'b1;
    bus.start_valid     = 1'b0;
    bus.palabraA        = '0;
    bus.palabraB        = '0;
    bus.resultado_ready = 1'b0;
    #12;
    check_bit("rst_start_ready", bus.start_ready, 1'b1);
    check_bit("rst_valid", bus.resultado_valid, 1'b0);
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_resultado", bus.resultado, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step();

    run_op("a5b3", 3'd5, 3'd3, 1'b1, 1'b0, 1'b1);
    release_ok("a5b3");
    check_bit("a5b3_keep", bus.resultado, 1'b1);
    run_op("a3b5", 3'd3, 3'd5, 1'b0, 1'b0, 1'b1);
    release_ok("a3b5");
    run_op("a6b6", 3'd6, 3'd6, 1'b0, 1'b1, 1'b1);
    release_ok("a6b6");
    run_op("a4b2", 3'd4, 3'd2, 1'b1, 1'b0, 1'b1);
    release_ok("a4b2");

    // Stall in DONE with stray start requests that would otherwise give a different verdict.
    run_op("a7b0", 3'd7, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.start_valid = i[0];
      bus.palabraA    = 3'd1;
      bus.palabraB    = 3'd6;
      step();
      check_bit("stall_valid", bus.resultado_valid, 1'b1);
      check_bit("stall_resultado", bus.resultado, 1'b1);
      check_bit("stall_no_accept", bus.start_ready, 1'b0);
      check_bit("stall_busy", bus.busy, 1'b0);
    end
    bus.start_valid = 1'b0;
    release_ok("stall");
    check_bit("idle_keep", bus.resultado, 1'b1);

    // Reset during the second RUN cycle, then a fresh comparison.
    bus.palabraA    = 3'd5;
    bus.palabraB    = 3'd3;
    bus.start_valid = 1'b1;
    step();
    bus.start_valid = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    check_bit("midrst_start_ready", bus.start_ready, 1'b1);
    check_bit("midrst_busy", bus.busy, 1'b0);
    check_bit("midrst_valid", bus.resultado_valid, 1'b0);
    check_bit("midrst_resultado", bus.resultado, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_bit("postrst_valid", bus.resultado_valid, 1'b0);
    run_op("a2b1", 3'd2, 3'd1, 1'b1, 1'b0, 1'b1);
    release_ok("a2b1");
    run_op("a1b1", 3'd1, 3'd1, 1'b0, 1'b1, 1'b1);
    release_ok("a1b1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
